// File: rtl/key_cmd_gen_if.sv
// SDRAM controller user-port bundle: command handshake plus the write and
// read beat channels. The command generator is the master side.
interface key_cmd_gen_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
);
    logic              cmd_req;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ack;
    logic              wr_data_req;
    logic [DATA_W-1:0] wr_data;
    logic              rd_data_vld;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output cmd_req, cmd_rw, cmd_addr, wr_data,
        input  cmd_ack, wr_data_req, rd_data_vld, rd_data
    );

    modport slave (
        input  cmd_req, cmd_rw, cmd_addr, wr_data,
        output cmd_ack, wr_data_req, rd_data_vld, rd_data
    );
endinterface

// File: rtl/key_cmd_gen.sv
// Key-press to SDRAM burst command generator. Turns debounced press pulses
// into write/read bursts, address steps and clears; sources an
// address-derived write pattern and checks read beats against the same
// pattern. One press can wait in a single-entry pending buffer while a
// burst is in flight; further presses are dropped and flagged.
module key_cmd_gen #(
    parameter int KEY_W     = 4,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_vld,
    key_cmd_gen_if.master    sd,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             drop
);

    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WDATA, S_RDATA, S_DONE} state_t;
    typedef enum logic [2:0] {EV_NONE, EV_WR, EV_RD, EV_INC, EV_CLR} ev_t;

    state_t            state, state_d;
    ev_t               key_ev, exec_ev;
    ev_t               pend_ev, pend_ev_d;
    logic              pend_vld, pend_vld_d;
    logic              drop_d;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_rw;
    logic [DATA_W-1:0] wr_data;
    logic [BEAT_W-1:0] beat;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] beat_pat;
    logic              wr_beat;
    logic              rd_beat;
    logic              beat_last;

    // Pattern for the current beat: low bits of the burst address plus beat.
    assign base      = DATA_W'(cmd_addr);
    assign beat_pat  = base + DATA_W'(beat);
    assign wr_beat   = (state == S_WDATA) && sd.wr_data_req;
    assign rd_beat   = (state == S_RDATA) && sd.rd_data_vld;
    assign beat_last = (beat == BEAT_LAST);

    assign sd.cmd_req  = (state == S_REQ);
    assign sd.cmd_rw   = cmd_rw;
    assign sd.cmd_addr = cmd_addr;
    assign sd.wr_data  = wr_data;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    // Priority decode of the press pulses: lowest index wins.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first; a path that skips an assignment would otherwise infer a latch.
        key_ev = EV_NONE;
        if      (key_vld[0]) key_ev = EV_WR;
        else if (key_vld[1]) key_ev = EV_RD;
        else if (key_vld[2]) key_ev = EV_INC;
        else if (key_vld[3]) key_ev = EV_CLR;
    end

    // Event executed this cycle: only in IDLE, and the older pending one first.
    always_comb begin
        exec_ev = EV_NONE;
        if (state == S_IDLE) exec_ev = pend_vld ? pend_ev : key_ev;
    end

    // Pending buffer refill/consume and drop detection.
    always_comb begin
        pend_vld_d = pend_vld;
        pend_ev_d  = pend_ev;
        drop_d     = 1'b0;
        if (state == S_IDLE) begin
            // Consuming the pending entry frees it for a same-cycle press.
            if (pend_vld) begin
                pend_vld_d = (key_ev != EV_NONE);
                pend_ev_d  = key_ev;
            end
        end else if (key_ev != EV_NONE) begin
            if (!pend_vld) begin
                pend_vld_d = 1'b1;
                pend_ev_d  = key_ev;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // Next-state logic of the burst sequencer.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (exec_ev == EV_WR || exec_ev == EV_RD) state_d = S_REQ;
            S_REQ:   if (sd.cmd_ack) state_d = cmd_rw ? S_WDATA : S_RDATA;
            S_WDATA: if (wr_beat && beat_last) state_d = S_DONE;
            S_RDATA: if (rd_beat && beat_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any burst and deasserts cmd_req at once.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // the pre-edge values, independent of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Datapath: address, command latch, beat counter, pattern, err, pending.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the pending entry is a control register, not storage, so it is
        // reset with everything else; a stale press must not survive reset.
        if (!rst_n) begin
            addr     <= '0;
            cmd_addr <= '0;
            cmd_rw   <= 1'b0;
            wr_data  <= '0;
            beat     <= '0;
            err      <= 1'b0;
            drop     <= 1'b0;
            pend_vld <= 1'b0;
            pend_ev  <= EV_NONE;
        end else begin
            drop     <= drop_d;
            pend_vld <= pend_vld_d;
            pend_ev  <= pend_ev_d;

            case (exec_ev)
                EV_WR, EV_RD: begin
                    cmd_addr <= addr;
                    cmd_rw   <= (exec_ev == EV_WR);
                end
                EV_INC: addr <= addr + ADDR_W'(BURST_LEN);
                EV_CLR: begin
                    addr <= '0;
                    err  <= 1'b0;
                end
                default: ;
            endcase

            if (state == S_REQ && sd.cmd_ack) begin
                beat    <= '0;
                wr_data <= base;
            end

            if (wr_beat) begin
                beat    <= beat + BEAT_W'(1);
                wr_data <= beat_pat + DATA_W'(1);
            end

            if (rd_beat) begin
                beat <= beat + BEAT_W'(1);
                if (sd.rd_data != beat_pat) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_cmd_gen.sv
// Bench for key_cmd_gen: a scripted SDRAM controller drives the user port,
// expected commands and beat data are queued when keys are pressed and
// popped as the DUT presents them. A second instance with a 4-bit address
// covers address wrap.
module tb_key_cmd_gen;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int BL     = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_vld = '0;
    logic [3:0] key_vld_b = '0;
    logic       busy, done, err, drop;
    logic       busy_b, done_b, err_b, drop_b;

    key_cmd_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
    key_cmd_gen_if #(.ADDR_W(4),      .DATA_W(DATA_W)) bus_b ();

    always #5 clk = ~clk;

    key_cmd_gen #(.KEY_W(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .key_vld(key_vld), .sd(bus_a),
        .busy(busy), .done(done), .err(err), .drop(drop)
    );

    key_cmd_gen #(.KEY_W(4), .ADDR_W(4), .DATA_W(DATA_W), .BURST_LEN(BL)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_vld(key_vld_b), .sd(bus_b),
        .busy(busy_b), .done(done_b), .err(err_b), .drop(drop_b)
    );

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    cmd_t              exp_cmd[$];
    logic [DATA_W-1:0] exp_wr[$];
    logic [DATA_W-1:0] exp_rd[$];
    logic [ADDR_W-1:0] m_addr = '0;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle press; queue what the press should eventually produce.
    task automatic press(input logic [3:0] v, input logic exp_drop);
        cmd_t              c;
        logic [DATA_W-1:0] b;
        key_vld = v;
        @(negedge clk);
        key_vld = '0;
        check("drop", 32'(drop), 32'(exp_drop));
        if (!exp_drop) begin
            if (v[0] || v[1]) begin
                c.rw   = v[0];
                c.addr = m_addr;
                exp_cmd.push_back(c);
                b = m_addr[DATA_W-1:0];
                for (int i = 0; i < BL; i++) begin
                    if (v[0]) exp_wr.push_back(b + DATA_W'(i));
                    else      exp_rd.push_back(b + DATA_W'(i));
                end
            end else if (v[2]) begin
                m_addr = m_addr + ADDR_W'(BL);
            end else if (v[3]) begin
                m_addr = '0;
            end
        end
    endtask

    task automatic wait_cmd();
        cmd_t c;
        int   n = 0;
        while (!bus_a.cmd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_seen", 32'(bus_a.cmd_req), 32'd1);
        check("sb_cmd_avail", 32'(exp_cmd.size() != 0), 32'd1);
        if (exp_cmd.size() != 0) begin
            c = exp_cmd.pop_front();
            check("cmd_rw", 32'(bus_a.cmd_rw), 32'(c.rw));
            check("cmd_addr", 32'(bus_a.cmd_addr), 32'(c.addr));
        end
    endtask

    task automatic ack_cmd(input int dly);
        repeat (dly) @(negedge clk);
        check("req_hold", 32'(bus_a.cmd_req), 32'd1);
        bus_a.cmd_ack = 1'b1;
        @(negedge clk);
        bus_a.cmd_ack = 1'b0;
        check("req_release", 32'(bus_a.cmd_req), 32'd0);
    endtask

    task automatic write_beats();
        logic [DATA_W-1:0] e;
        for (int i = 0; i < BL; i++) begin
            e = (exp_wr.size() != 0) ? exp_wr.pop_front() : 'x;
            bus_a.wr_data_req = 1'b1;
            check("wr_data", 32'(bus_a.wr_data), 32'(e));
            @(negedge clk);
        end
        bus_a.wr_data_req = 1'b0;
    endtask

    task automatic read_beats(input int bad);
        logic [DATA_W-1:0] e;
        for (int i = 0; i < BL; i++) begin
            e = (exp_rd.size() != 0) ? exp_rd.pop_front() : '0;
            bus_a.rd_data     = (i == bad) ? 16'hFFFF : e;
            bus_a.rd_data_vld = 1'b1;
            @(negedge clk);
        end
        bus_a.rd_data_vld = 1'b0;
    endtask

    // Ends on the IDLE cycle that follows the single done pulse.
    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done", 32'(done), 32'd1);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    // Read burst on the 4-bit-address instance with matching data.
    task automatic b_read(input int exp_addr);
        key_vld_b = 4'b0010;
        @(negedge clk);
        key_vld_b = '0;
        check("b_req", 32'(bus_b.cmd_req), 32'd1);
        check("b_addr", 32'(bus_b.cmd_addr), 32'(exp_addr));
        bus_b.cmd_ack = 1'b1;
        @(negedge clk);
        bus_b.cmd_ack = 1'b0;
        for (int i = 0; i < BL; i++) begin
            bus_b.rd_data     = DATA_W'(exp_addr + i);
            bus_b.rd_data_vld = 1'b1;
            @(negedge clk);
        end
        bus_b.rd_data_vld = 1'b0;
        check("b_done", 32'(done_b), 32'd1);
        @(negedge clk);
        check("b_err", 32'(err_b), 32'd0);
    endtask

    task automatic b_inc();
        key_vld_b = 4'b0100;
        @(negedge clk);
        key_vld_b = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic              seen_done;
        logic [DATA_W-1:0] e;
        bus_a.cmd_ack = 0; bus_a.wr_data_req = 0; bus_a.rd_data_vld = 0; bus_a.rd_data = '0;
        bus_b.cmd_ack = 0; bus_b.wr_data_req = 0; bus_b.rd_data_vld = 0; bus_b.rd_data = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_cmd_req", 32'(bus_a.cmd_req), 32'd0);
        check("rst_cmd_rw", 32'(bus_a.cmd_rw), 32'd0);
        check("rst_cmd_addr", 32'(bus_a.cmd_addr), 32'd0);
        check("rst_wr_data", 32'(bus_a.wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write burst at address 0, ack after 3 cycles.
        press(4'b0001, 1'b0);
        check("req_t1", 32'(bus_a.cmd_req), 32'd1);
        wait_cmd();
        ack_cmd(3);
        write_beats();
        wait_done();

        // Two address steps then a clean read at 16.
        press(4'b0100, 1'b0);
        press(4'b0100, 1'b0);
        press(4'b0010, 1'b0);
        wait_cmd();
        ack_cmd(2);
        read_beats(-1);
        wait_done();
        check("err_clean", 32'(err), 32'd0);

        // Corrupted beat 5 sets a sticky err; clear resets it.
        press(4'b0010, 1'b0);
        wait_cmd();
        ack_cmd(1);
        read_beats(5);
        wait_done();
        check("err_set", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        press(4'b1000, 1'b0);
        check("err_clr", 32'(err), 32'd0);

        // Pending write while busy, a third press is dropped.
        press(4'b0001, 1'b0);
        wait_cmd();
        press(4'b0001, 1'b0);
        press(4'b0010, 1'b1);
        @(negedge clk);
        check("drop_pulse", 32'(drop), 32'd0);
        ack_cmd(0);
        write_beats();
        wait_done();
        @(negedge clk);
        check("pend_no_gap", 32'(bus_a.cmd_req), 32'd1);
        wait_cmd();
        ack_cmd(1);
        write_beats();
        wait_done();

        // Multi-bit press: read wins, no step, no drop.
        press(4'b1110, 1'b0);
        wait_cmd();
        ack_cmd(0);
        read_beats(-1);
        wait_done();

        // Clear from pending wipes err set by the preceding burst.
        press(4'b0010, 1'b0);
        wait_cmd();
        press(4'b1000, 1'b0);
        ack_cmd(0);
        read_beats(2);
        wait_done();
        check("err_before_pend_clr", 32'(err), 32'd1);
        @(negedge clk);
        check("err_pend_clr", 32'(err), 32'd0);

        // Reset in the middle of a read burst with a pending press.
        press(4'b0100, 1'b0);
        press(4'b0010, 1'b0);
        wait_cmd();
        ack_cmd(1);
        e = (exp_rd.size() != 0) ? exp_rd.pop_front() : '0;
        bus_a.rd_data     = ~e;
        bus_a.rd_data_vld = 1'b1;
        @(negedge clk);
        bus_a.rd_data_vld = 1'b0;
        check("err_pre_rst", 32'(err), 32'd1);
        press(4'b0001, 1'b0);
        check("busy_pre_rst", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_req", 32'(bus_a.cmd_req), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_err", 32'(err), 32'd0);
        exp_cmd.delete();
        exp_wr.delete();
        exp_rd.delete();
        m_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        check("no_done_after_rst", 32'(seen_done), 32'd0);
        check("pend_lost", 32'(busy), 32'd0);
        press(4'b0001, 1'b0);
        wait_cmd();
        ack_cmd(0);
        write_beats();
        wait_done();

        // 4-bit address wraps: 8 -> 0 -> 8.
        b_inc();
        b_read(8);
        b_inc();
        b_read(0);
        b_inc();
        b_read(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/key_cmd_gen.md
Name: key_cmd_gen

Overview:
- Consumes the one-cycle, one-hot-per-key press pulses from the debounce stage and converts them into SDRAM burst commands.
- Sits between key debounce and the SDRAM controller user port.
- Drives a req/ack command handshake, sources write-burst data, and checks read-burst data against the expected pattern.
- Buffers one press while busy; flags presses it must drop.

Parameters:
KEY_W, 4, width of key_vld; bits 0..3 are decoded, any higher bits are ignored
ADDR_W, 22, SDRAM user address width (bank+row+col)
DATA_W, 16, SDRAM data width
BURST_LEN, 8, beats per burst (power of 2, 2..256)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_vld  in  KEY_W  press pulses, 1 cycle each; bit0=write, bit1=read, bit2=addr+BURST_LEN, bit3=clear
cmd_req  out  1  command request, held until cmd_ack
cmd_rw  out  1  1=write, 0=read; valid while cmd_req
cmd_addr  out  ADDR_W  burst start address; valid while cmd_req
cmd_ack  in  1  controller accepts command (1 cycle)
wr_data_req  in  1  controller consumes wr_data this cycle
wr_data  out  DATA_W  write beat data
rd_data_vld  in  1  read beat valid
rd_data  in  DATA_W  read beat data
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at end of each burst
err  out  1  sticky read-compare mismatch
drop  out  1  1-cycle pulse when a press is discarded

Behaviour:
- Reset (async): state=IDLE, addr=0, pending empty, beat=0. All outputs 0: cmd_req, cmd_rw, cmd_addr, wr_data, busy, done, err, drop.
- Decode: if several key_vld bits are set in one cycle, the lowest index wins and the others are silently discarded. key_vld==0 means no event.
- States: IDLE, REQ, WDATA, RDATA, DONE.
- IDLE event source: the pending entry if valid, otherwise the new key event.
  - Write/read event: latch cmd_addr=addr and cmd_rw, then go to REQ. cmd_req is high the cycle after the key pulse.
  - Addr-increment event: addr <= addr+BURST_LEN, wrapping mod 2^ADDR_W. Executes in 1 cycle; no handshake; state stays IDLE.
  - Clear event: addr <= 0, err <= 0. 1 cycle; state stays IDLE.
  - If pending is consumed and a new key arrives in the same cycle, the new key goes into pending.
- Pending buffer: one entry.
  - A key event arriving while state != IDLE is stored in pending if empty.
  - If pending is full, the event is discarded and drop pulses high for 1 cycle.
- REQ: cmd_req=1 with cmd_rw/cmd_addr held stable. On cmd_ack: cmd_req=0 next cycle, beat=0, go to WDATA (write) or RDATA (read).
- WDATA: wr_data = cmd_addr[DATA_W-1:0]+beat, truncated to DATA_W, registered.
  - wr_data is valid from the first WDATA cycle.
  - Each wr_data_req cycle: the controller samples the current value; beat increments and wr_data updates the next cycle.
  - After BURST_LEN requests, go to DONE.
- RDATA: each rd_data_vld cycle compares rd_data against cmd_addr[DATA_W-1:0]+beat; a mismatch sets err=1 (sticky); beat increments. After BURST_LEN valid beats, go to DONE.
- DONE: done=1 for exactly 1 cycle, then IDLE. The pending entry, if any, is serviced in that IDLE cycle.
- Ignored inputs:
  - cmd_ack outside REQ.
  - wr_data_req outside WDATA.
  - rd_data_vld outside RDATA.
- Clear via pending: a clear executed from pending resets err, even if err was set by the preceding burst.
- Reset mid-burst: returns to IDLE immediately, pending is lost, cmd_req deasserts asynchronously.
- Beat counter width: clog2(BURST_LEN)+1.

Test Plan:
- Reset, key_vld=4'b0001 at cycle t -> cmd_req=1, cmd_rw=1, cmd_addr=0 at t+1. Ack after 3 cycles; 8 wr_data_req on consecutive cycles -> wr_data 0..7, one done pulse, busy back to 0.
- key_vld=4'b0100 twice, then 4'b0010 -> read request at cmd_addr=16. Controller returns 16..23 -> done pulse, err=0. Repeat with beat 5 returning 0xFFFF -> err=1 and it stays 1. key_vld=4'b1000 -> err=0, addr=0.
- During a write burst send 0001 then 0010 -> first press held in pending; second press gives drop=1 for 1 cycle. After done, the pending write is issued with no idle gap beyond 1 IDLE cycle.
- key_vld=4'b1110 in IDLE -> read only, no addr change, no drop.
- ADDR_W=4, BURST_LEN=8: press 0100 twice from addr 8 -> addr wraps to 8 after 0, i.e. 8->0->8.
- Assert rst_n=0 mid-RDATA with pending valid -> cmd_req=0, busy=0, err=0 immediately. No done pulse after release; a subsequent press starts at addr 0.
